// File: rtl/reg_pipe_enable_if.sv
// Stream handshake bundle for reg_pipe_enable: producer side (in_*) and consumer side (out_*).
// The pipeline connects through the slave modport.
interface reg_pipe_enable_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/reg_pipe_enable.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit data with per-stage valid,
// global enable, synchronous flush and bubble collapsing.
module reg_pipe_enable #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         flush,
   reg_pipe_enable_if.slave             bus,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] adv;
   logic [WIDTH-1:0] data [DEPTH];
   logic             go;
   logic             in_acc;
   logic             out_acc;

   assign go = enable & ~flush;

   // Ready chain walks from the output back to stage 0; a scalar carries the
   // downstream advance so no vector bit depends on another bit of itself.
   always_comb begin
      logic a;
      adv = '0;
      a = valid[DEPTH-1] & bus.out_ready & go;
      adv[DEPTH-1] = a;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         int unsigned i;
         i = DEPTH - 1 - k;
         a = valid[i] & go & (~valid[i+1] | a);
         adv[i] = a;
      end
   end

   assign bus.in_ready  = go & (~valid[0] | adv[0]);
   assign in_acc        = bus.in_valid & bus.in_ready;
   assign out_acc       = adv[DEPTH-1];
   assign bus.out_valid = valid[DEPTH-1] & go;
   assign bus.out_data  = data[DEPTH-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
      end else if (flush) begin
         valid <= '0;
         count <= '0;
      end else begin
         // With enable low every adv bit and in_acc are zero, so state holds.
         if (in_acc) begin
            data[0]  <= bus.in_data;
            valid[0] <= 1'b1;
         end else if (adv[0]) begin
            valid[0] <= 1'b0;
         end
         for (int unsigned i = 1; i < DEPTH; i++) begin
            if (adv[i-1]) begin
               data[i]  <= data[i-1];
               valid[i] <= 1'b1;
            end else if (adv[i]) begin
               valid[i] <= 1'b0;
            end
         end
         count <= count + CW'(in_acc) - CW'(out_acc);
      end
   end
endmodule

// File: doc/reg_pipe_enable.md
# reg_pipe_enable

Parametrised, elastic register pipeline: DEPTH stages of WIDTH-bit registers with per-stage valid bits, valid/ready handshakes on both ends, a global enable (stall) and a synchronous flush. It generalises the single-bit enabled flip-flop cell into a multi-bit, multi-stage buffer. It sits between producer and consumer datapaths that need fixed registered latency, back-pressure and bubble collapsing.

## Interface
- WIDTH, 32, data bits per word (>=1)
- DEPTH, 4, number of register stages (>=1)
- RESET_VAL, '0, value loaded into every stage's data register on reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset; one clock, no asynchronous paths
- enable  in  1  global enable; 0 freezes all state and blocks both handshakes
- flush  in  1  synchronous clear of all valid bits
- in_valid  in  1  producer has a word on in_data
- in_ready  out  1  pipeline accepts in_data this cycle
- in_data  in  WIDTH  input word
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  WIDTH  data register of stage DEPTH-1
- count  out  $clog2(DEPTH+1)  number of valid stages (registered)

## Operation
- State: valid[i], data[i] for i = 0..DEPTH-1; stage 0 is input side, DEPTH-1 drives outputs.
- Reset (priority over everything): valid = 0, data = RESET_VAL, count = 0. Outputs after reset: in_ready = enable, out_valid = 0, out_data = RESET_VAL.
- out_valid = valid[DEPTH-1] & enable & ~flush.
- Advance signals (combinational, computed from output backwards): adv[DEPTH-1] = valid[DEPTH-1] & out_ready & enable & ~flush; for i < DEPTH-1, adv[i] = valid[i] & enable & ~flush & (~valid[i+1] | adv[i+1]).
- in_ready = enable & ~flush & (~valid[0] | adv[0]). Input handshake: in_valid & in_ready.
- Per edge when not reset/flush: stage i+1 loads data[i] and valid[i+1]=1 if adv[i]; else valid[i+1] clears if adv[i+1], otherwise holds. Stage 0 loads in_data when input handshake occurs.
- Bubble collapsing: a word moves forward whenever the next stage is empty or emptying, regardless of downstream stall; empty stages never block.
- Data registers load only on accept; data of non-valid stages is don't-care but must not change unless loaded (clock-enable style, no free-running mux).
- enable = 0: no valid/data/count change; in_ready = 0; out_valid = 0.
- flush = 1 (enable irrelevant): all valid clear next edge, data unchanged, count = 0; no handshake occurs that cycle (in_ready = out_valid = 0).
- count next = count + in_accept - out_accept; never exceeds DEPTH, never underflows.

## Timing
- Latency: word accepted at edge t appears with out_valid=1 in cycle t+DEPTH when all stages empty and enable held high (one register per stage).
- Throughput: one word per cycle sustained with out_ready=1; no bubble inserted on out_ready toggling.
- Full: count == DEPTH with out_ready=0 -> in_ready=0. Full with out_ready=1 -> in_ready=1 same cycle (pass-through ready chain, simultaneous in and out accept, count unchanged).
- Empty: count == 0 -> out_valid=0, in_ready=enable & ~flush.
- Ready chain is combinational out_ready -> in_ready (DEPTH levels); no combinational path from in_valid/in_data to any output.
- Reset or flush mid-stream discards all in-flight words; first accept after is next cycle.

## Test plan
- Reset: assert reset 2 cycles with RESET_VAL=8'hA5, WIDTH=8, DEPTH=4 -> out_valid=0, count=0, out_data=8'hA5, in_ready=1.
- Streaming: out_ready=1, push 1,2,3,... one per cycle -> word 1 at out_valid after 4 cycles, then one word per cycle in order, count steady at 4.
- Back-pressure: out_ready=0, push 6 words -> in_ready drops after 4 accepts, count=4; raise out_ready -> words 1..6 drain in order, no loss/duplication.
- Bubble collapse: push word at cycle 0 and 3 with out_ready=0 -> both pack into stages 3 and 2 (count=2); releasing out_ready gives back-to-back output.
- Enable low: mid-stream drop enable 3 cycles -> in_ready=out_valid=0, data/count frozen; resume yields identical sequence with 3-cycle shift.
- Flush: full pipe, flush with in_valid=out_ready=1 -> neither word accepted, count=0 next cycle, out_valid=0; reset+flush together behaves as reset.
